// File: rtl/shift_unit.sv
// shift_unit: multi-cycle SLL/SRL/SRA/ROR shifter, STEP bits per clock, valid/ready operand and result handshakes
module shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     busy
);
  localparam int SHAMT_W = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] data, hi, nxt;
  logic [2*WIDTH-1:0] wide;
  logic [SHAMT_W-1:0] count, s;
  logic [1:0] mode;
  logic sign;
  always_comb begin
    s = (int'(count) < STEP) ? count : SHAMT_W'(STEP);
    hi = mode == 2'b11 ? data : mode == 2'b10 ? {WIDTH{sign}} : '0;
    wide = {hi, data} >> s;
    nxt = mode == 2'b00 ? data << s : wide[WIDTH-1:0];
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign out_data = state == DONE ? data : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data <= '0;
      count <= '0;
      mode <= '0;
      sign <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          data <= in_data;
          count <= in_shamt;
          mode <= in_mode;
          sign <= in_data[WIDTH-1];
          state <= in_shamt != '0 ? SHIFT : DONE;
        end
        SHIFT: begin
          data <= nxt;
          count <= count - s;
          state <= count == s ? DONE : SHIFT;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: directed and random checks of shift_unit at STEP 1, 2, 4, 8 and 32
module tb_shift_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] in_valid = '0, out_ready = '0, in_ready, out_valid, busy;
  logic [31:0] in_data = '0;
  logic [4:0] in_shamt = '0;
  logic [1:0] in_mode = '0;
  logic [4:0][31:0] od;
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 5; g++) begin : u
    shift_unit #(.WIDTH(32), .STEP(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 4 : g == 3 ? 8 : 32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data),
      .in_shamt(in_shamt), .in_mode(in_mode), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_data(od[g]), .busy(busy[g]));
  end
  function automatic int step_of(int k);
    return k == 0 ? 1 : k == 1 ? 2 : k == 2 ? 4 : k == 3 ? 8 : 32;
  endfunction
  function automatic logic [31:0] model(logic [31:0] d, int sh, logic [1:0] md);
    logic [31:0] r = d;
    for (int i = 0; i < sh; i++)
      case (md)
        2'd0: r = {r[30:0], 1'b0};
        2'd1: r = {1'b0, r[31:1]};
        2'd2: r = {d[31], r[31:1]};
        default: r = {r[0], r[31:1]};
      endcase
    return r;
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic issue(int k, logic [31:0] d, int sh, logic [1:0] md);
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_data = d;
    in_shamt = sh[4:0];
    in_mode = md;
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask
  task automatic wait_done(int k, output int cyc, output logic allbusy);
    cyc = 0;
    allbusy = 1'b1;
    while (!out_valid[k] && cyc < 100) begin
      allbusy &= busy[k];
      @(negedge clk);
      cyc++;
    end
    allbusy &= busy[k];
  endtask
  task automatic run(string tag, int k, logic [31:0] d, int sh, logic [1:0] md);
    int cyc;
    logic ab;
    issue(k, d, sh, md);
    wait_done(k, cyc, ab);
    check({tag, " lat"}, cyc, (sh + step_of(k) - 1) / step_of(k));
    check({tag, " data"}, od[k], model(d, sh, md));
    check({tag, " busy"}, ab, 1);
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    check({tag, " idle"}, {in_ready[k], out_valid[k], busy[k]}, 3'b100);
  endtask
  initial begin
    int cyc;
    logic ab;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("reset flags", {in_ready[k], out_valid[k], busy[k]}, 3'b100);
      check("reset data", od[k], 0);
    end
    run("sll2", 0, 32'h1, 2, 2'd0);
    check("sll2 const", model(32'h1, 2, 2'd0), 32'h4);
    run("sra31", 0, 32'h80000000, 31, 2'd2);
    check("sra31 const", model(32'h80000000, 31, 2'd2), 32'hffffffff);
    run("srl31", 0, 32'h80000000, 31, 2'd1);
    check("srl31 const", model(32'h80000000, 31, 2'd1), 32'h1);
    run("ror8 s1", 0, 32'h12345678, 8, 2'd3);
    run("ror8 s4", 2, 32'h12345678, 8, 2'd3);
    check("ror8 const", model(32'h12345678, 8, 2'd3), 32'h78123456);
    run("sra31 s32", 4, 32'h80000000, 31, 2'd2);
    run("ror31 s8", 3, 32'h0000000f, 31, 2'd3);
    issue(0, 32'hdeadbeef, 0, 2'd0);
    check("sh0 lat", out_valid[0], 1);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1;
      in_data = 32'h11111111;
      in_shamt = 5'd3;
      @(negedge clk);
      check("hold valid", out_valid[0], 1);
      check("hold data", od[0], 32'hdeadbeef);
      check("hold ready", in_ready[0], 0);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("hold release", {in_ready[0], busy[0]}, 2'b10);
    issue(0, 32'h0000ffff, 20, 2'd0);
    repeat (10) @(negedge clk);
    check("abort busy", busy[0], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort flags", {in_ready[0], out_valid[0], busy[0]}, 3'b100);
    check("abort data", od[0], 0);
    run("post abort", 0, 32'h3, 1, 2'd0);
    check("post abort const", model(32'h3, 1, 2'd0), 32'h6);
    @(negedge clk);
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    in_data = 32'h1;
    in_shamt = 5'd1;
    in_mode = 2'd0;
    @(negedge clk);
    wait_done(0, cyc, ab);
    check("b2b first lat", cyc, 1);
    check("b2b first data", od[0], 32'h2);
    in_data = 32'h5;
    in_shamt = 5'd3;
    @(negedge clk);
    cyc = 1;
    while (!out_valid[0] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    in_valid[0] = 1'b0;
    check("b2b spacing", cyc, 5);
    check("b2b second data", od[0], 32'h28);
    @(negedge clk);
    out_ready[0] = 1'b0;
    for (int k = 0; k < 5; k++)
      for (int n = 0; n < 200; n++)
        run("rand", k, $urandom, $urandom_range(0, 31), 2'($urandom_range(0, 3)));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
